// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the single regfile write port between pipeline
// writeback (A) and long-latency results (B). A has priority. B is force-granted
// after STARVE_LIMIT consecutive denied cycles. A destination scoreboard lets
// issue logic stall on hazards against in-flight B operations.
module regfile_wb_arbiter #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  a_valid,
    input  logic [ADDR_W-1:0]     a_addr,
    input  logic [DATA_W-1:0]     a_data,
    output logic                  a_ready,
    input  logic                  b_valid,
    input  logic [ADDR_W-1:0]     b_addr,
    input  logic [DATA_W-1:0]     b_data,
    output logic                  b_ready,
    input  logic                  rsv_valid,
    input  logic [ADDR_W-1:0]     rsv_addr,
    input  logic [ADDR_W-1:0]     chk_rs1,
    input  logic [ADDR_W-1:0]     chk_rs2,
    input  logic [ADDR_W-1:0]     chk_rd,
    output logic                  hazard,
    output logic [2**ADDR_W-1:0]  busy,
    output logic                  write_reg,
    output logic [ADDR_W-1:0]     dstreg_addr,
    output logic [DATA_W-1:0]     dstreg_data,
    output logic                  err
);

    localparam int NREG = 2**ADDR_W;
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0]      starve_cnt;
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_next;
    logic            err_q;
    logic            force_b;
    logic            a_xfer;
    logic            b_xfer;
    logic            rsv_hit;
    logic            err_set;

    assign busy   = busy_q;
    assign err    = err_q;
    assign hazard = busy_q[chk_rs1] | busy_q[chk_rs2] | busy_q[chk_rd];

    // Grant selection; every output is held low while reset is asserted so
    // the port goes quiet the moment rst_n falls.
    always_comb begin
        force_b = b_valid && (starve_cnt == LIMIT);
        a_ready = 1'b0;
        b_ready = 1'b0;
        if (rst_n) begin
            if (force_b) begin
                b_ready = 1'b1;
            end else begin
                a_ready = 1'b1;
                b_ready = b_valid & ~a_valid;
            end
        end
        a_xfer = a_valid & a_ready;
        b_xfer = b_valid & b_ready;
    end

    // Steer the accepted transfer onto the regfile write port; r0 writes are swallowed.
    always_comb begin
        write_reg   = 1'b0;
        dstreg_addr = '0;
        dstreg_data = '0;
        if (a_xfer) begin
            write_reg   = (a_addr != '0);
            dstreg_addr = a_addr;
            dstreg_data = a_data;
        end else if (b_xfer) begin
            write_reg   = (b_addr != '0);
            dstreg_addr = b_addr;
            dstreg_data = b_data;
        end
    end

    // Next scoreboard value and protocol-error detection; a new reservation
    // beats a same-cycle clear of the same register.
    always_comb begin
        rsv_hit   = rsv_valid && (rsv_addr != '0);
        busy_next = busy_q;
        if (b_xfer) begin
            busy_next[b_addr] = 1'b0;
        end
        if (rsv_hit) begin
            busy_next[rsv_addr] = 1'b1;
        end
        busy_next[0] = 1'b0;
        err_set = (rsv_hit && busy_q[rsv_addr] && !(b_xfer && (b_addr == rsv_addr)))
                | (b_xfer && (b_addr != '0) && !busy_q[b_addr])
                | (a_xfer && busy_q[a_addr]);
    end

    // State registers: starvation counter, scoreboard and sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
            busy_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            if (!b_valid || b_xfer) begin
                starve_cnt <= '0;
            end else if (starve_cnt != LIMIT) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
            busy_q <= busy_next;
            if (err_set) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: a stimulus process predicts each
// cycle's outputs from a register-array model and queues them; a monitor
// compares the DUT against the queue on every falling edge.
module tb_regfile_wb_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        a_valid = 1'b0, b_valid = 1'b0, rsv_valid = 1'b0;
    logic [4:0]  a_addr = '0, b_addr = '0, rsv_addr = '0;
    logic [4:0]  chk_rs1 = '0, chk_rs2 = '0, chk_rd = '0;
    logic [31:0] a_data = '0, b_data = '0;
    logic        a_ready, b_ready, hazard, write_reg, err;
    logic [31:0] busy;
    logic [4:0]  dstreg_addr;
    logic [31:0] dstreg_data;

    regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
        .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
        .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .chk_rd(chk_rd),
        .hazard(hazard), .busy(busy), .write_reg(write_reg),
        .dstreg_addr(dstreg_addr), .dstreg_data(dstreg_data), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ar, br, wr, hz, er;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] bz;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;

    // reference model state
    bit m_busy[32];
    int m_denied;
    bit m_err;
    bit hold_a, hold_b;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] busy_vec();
        logic [31:0] v;
        for (int i = 0; i < 32; i++) v[i] = m_busy[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
        m_denied = 0;
        m_err = 1'b0;
        hold_a = 1'b0;
        hold_b = 1'b0;
    endtask

    // Predict this cycle from the model and current inputs, queue it, advance the model, then clock.
    task automatic step();
        exp_t e;
        bit forced, acc_a, acc_b;
        forced = b_valid && (m_denied >= LIMIT);
        e.ar = !forced;
        e.br = forced ? 1'b1 : (b_valid && !a_valid);
        acc_a = a_valid && e.ar;
        acc_b = b_valid && e.br;
        e.wr = 1'b0; e.addr = '0; e.data = '0;
        if (acc_a) begin
            e.wr = (a_addr != 0); e.addr = a_addr; e.data = a_data;
        end else if (acc_b) begin
            e.wr = (b_addr != 0); e.addr = b_addr; e.data = b_data;
        end
        e.hz = m_busy[chk_rs1] || m_busy[chk_rs2] || m_busy[chk_rd];
        e.bz = busy_vec();
        e.er = m_err;
        exp_q.push_back(e);
        if (rsv_valid && rsv_addr != 0 && m_busy[rsv_addr] && !(acc_b && b_addr == rsv_addr)) m_err = 1'b1;
        if (acc_b && b_addr != 0 && !m_busy[b_addr]) m_err = 1'b1;
        if (acc_a && m_busy[a_addr]) m_err = 1'b1;
        if (acc_b) m_busy[b_addr] = 1'b0;
        if (rsv_valid && rsv_addr != 0) m_busy[rsv_addr] = 1'b1;
        m_busy[0] = 1'b0;
        if (b_valid && !acc_b) m_denied = (m_denied + 1 > LIMIT) ? LIMIT : m_denied + 1;
        else m_denied = 0;
        hold_a = a_valid && !acc_a;
        hold_b = b_valid && !acc_b;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        a_valid = 0; b_valid = 0; rsv_valid = 0;
        a_addr = 0; b_addr = 0; rsv_addr = 0;
        a_data = 0; b_data = 0;
        chk_rs1 = 0; chk_rs2 = 0; chk_rd = 0;
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_a_ready"}, 32'(a_ready), 32'd0);
        chk({tag, "_b_ready"}, 32'(b_ready), 32'd0);
        chk({tag, "_write_reg"}, 32'(write_reg), 32'd0);
        chk({tag, "_dst_addr"}, 32'(dstreg_addr), 32'd0);
        chk({tag, "_dst_data"}, dstreg_data, 32'd0);
        chk({tag, "_busy"}, busy, 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
    endtask

    // Monitor: compare the DUT against the oldest prediction on each falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("a_ready", 32'(a_ready), 32'(e.ar));
                chk("b_ready", 32'(b_ready), 32'(e.br));
                chk("write_reg", 32'(write_reg), 32'(e.wr));
                chk("dstreg_addr", 32'(dstreg_addr), 32'(e.addr));
                chk("dstreg_data", dstreg_data, e.data);
                chk("hazard", 32'(hazard), 32'(e.hz));
                chk("busy", busy, e.bz);
                chk("err", 32'(err), 32'(e.er));
            end
        end
    end

    initial begin
        int bq[$];
        model_reset();
        idle_inputs();
        a_valid = 1; b_valid = 1;
        #3;
        check_quiet("reset_init");
        idle_inputs();
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;

        // pipeline write to r3
        a_valid = 1; a_addr = 3; a_data = 32'hDEADBEEF;
        step();
        idle_inputs();

        // reserve r7, observe hazard, retire it through B, hazard drops
        rsv_valid = 1; rsv_addr = 7;
        step();
        rsv_valid = 0; chk_rs1 = 7;
        step();
        b_valid = 1; b_addr = 7; b_data = 32'h12345678;
        step();
        b_valid = 0;
        step();
        idle_inputs();

        // starvation: A and B both held, B must be forced after LIMIT denials
        rsv_valid = 1; rsv_addr = 11;
        step();
        rsv_valid = 0;
        a_valid = 1; a_addr = 2; a_data = 32'h0000_0A0A;
        b_valid = 1; b_addr = 11; b_data = 32'hB0B0_B0B0;
        for (int i = 0; i < LIMIT + 1; i++) step();
        b_valid = 0;
        step();
        step();
        idle_inputs();

        // r0 writes and reservations are swallowed
        a_valid = 1; a_addr = 0; a_data = 32'hFFFFFFFF;
        rsv_valid = 1; rsv_addr = 0;
        step();
        idle_inputs();
        step();

        // same-cycle clear and reserve of r9, then a bad re-reservation
        rsv_valid = 1; rsv_addr = 9;
        step();
        b_valid = 1; b_addr = 9; b_data = 32'h9999_0000;
        step();
        idle_inputs();
        chk_rd = 9;
        step();
        rsv_valid = 1; rsv_addr = 9;
        step();
        idle_inputs();
        step();
        step();

        // async reset mid-cycle with reservations outstanding
        rsv_valid = 1; rsv_addr = 4;
        step();
        rsv_addr = 5;
        step();
        rsv_valid = 0;
        a_valid = 1; a_addr = 6; b_valid = 1; b_addr = 4;
        #2;
        rst_n = 0;
        #1;
        check_quiet("reset_mid");
        model_reset();
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
        a_valid = 1; a_addr = 8; a_data = 32'h0808_0808;
        step();
        idle_inputs();

        // randomized traffic honouring the hold-while-stalled rule
        for (int n = 0; n < 500; n++) begin
            if (!hold_a) begin
                a_valid = ($urandom_range(0, 2) != 0);
                a_addr = 5'($urandom);
                a_data = $urandom;
            end
            if (!hold_b) begin
                b_valid = ($urandom_range(0, 1) != 0);
                bq.delete();
                for (int i = 1; i < 32; i++) if (m_busy[i]) bq.push_back(i);
                if (bq.size() > 0 && $urandom_range(0, 3) != 0)
                    b_addr = 5'(bq[$urandom_range(0, bq.size() - 1)]);
                else
                    b_addr = 5'($urandom);
                b_data = $urandom;
            end
            rsv_valid = ($urandom_range(0, 3) == 0);
            rsv_addr = 5'($urandom);
            chk_rs1 = 5'($urandom);
            chk_rs2 = 5'($urandom);
            chk_rd = 5'($urandom);
            step();
        end
        idle_inputs();

        @(negedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
